// File: rtl/qcounter_param_pkg.sv
// Shared phase encodings, step decode and flag payload for the quadrature counter.
package qcounter_param_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic err;
    logic idx_seen;
  } qc_flags_t;

  // Gray-code walk: 00->01->11->10->00 is up; diagonal jumps are illegal.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = STEP_ERR;
    if (prev == cur) begin
      s = STEP_NONE;
    end else begin
      case ({prev, cur})
        {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: s = STEP_UP;
        {PH_01, PH_00}, {PH_11, PH_01}, {PH_10, PH_11}, {PH_00, PH_10}: s = STEP_DN;
        default: s = STEP_ERR;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/qcounter_param_filter.sv
// Two-flop synchroniser followed by an all-taps-agree hold filter for one encoder pin.
module qc_filter #(
  parameter int unsigned FILT_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic filterce,
  input  logic din,
  output logic dout
);

  logic                  sync1;
  logic                  sync2;
  logic [FILT_DEPTH-1:0] taps;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      taps  <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (filterce) begin
        taps <= {taps[FILT_DEPTH-2:0], sync2};
      end
      // Output only moves once every tap agrees; mixed taps hold the last value.
      if (&taps) begin
        dout <= 1'b1;
      end else if (~|taps) begin
        dout <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/qcounter_param.sv
// Quadrature position counter: filtered A/B/index decode, up/down count, sticky flags,
// index homing and a byte-readable snapshot register.
module qcounter_param
  import qcounter_param_pkg::*;
#(
  parameter int unsigned      WIDTH      = 16,
  parameter int unsigned      FILT_DEPTH = 4,
  parameter logic [WIDTH-1:0] INDEX_VAL  = '0,
  localparam int unsigned     SELW       = (WIDTH > 8) ? $clog2(WIDTH / 8) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             filterce,
  input  logic [1:0]       tach,
  input  logic             index,
  input  logic             invphase,
  input  logic             freeze,
  input  logic             idx_en,
  input  logic             clr,
  input  logic             clr_flags,
  input  logic             latch,
  input  logic [SELW-1:0]  rd_sel,
  output logic [7:0]       rd_data,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             unf,
  output logic             err,
  output logic             idx_seen
);

  localparam int unsigned NBYTES = WIDTH / 8;

  logic       a_f;
  logic       b_f;
  logic       idx_f;
  logic       idx_last;
  logic [1:0] ph_new;
  logic [1:0] ph_last;
  step_t      step;
  logic       idx_load;
  logic       step_apply;
  qc_flags_t  flags_q;
  qc_flags_t  flags_set;
  logic [WIDTH-1:0] snap;

  qc_filter #(.FILT_DEPTH(FILT_DEPTH)) u_filt_a (
    .clk(clk), .reset(reset), .filterce(filterce), .din(tach[0]), .dout(a_f)
  );
  qc_filter #(.FILT_DEPTH(FILT_DEPTH)) u_filt_b (
    .clk(clk), .reset(reset), .filterce(filterce), .din(tach[1]), .dout(b_f)
  );
  qc_filter #(.FILT_DEPTH(FILT_DEPTH)) u_filt_idx (
    .clk(clk), .reset(reset), .filterce(filterce), .din(index), .dout(idx_f)
  );

  // Decode and qualify this cycle's step, index load and flag sets.
  always_comb begin
    ph_new     = invphase ? {a_f, b_f} : {b_f, a_f};
    step       = decode_step(ph_last, ph_new);
    idx_load   = idx_en & idx_f & ~idx_last;
    step_apply = ~clr & ~idx_load & ~freeze;
    flags_set  = '0;
    flags_set.ovf      = step_apply && (step == STEP_UP) && (&count);
    flags_set.unf      = step_apply && (step == STEP_DN) && (count == '0);
    flags_set.err      = (step == STEP_ERR);
    flags_set.idx_seen = idx_load & ~clr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_last  <= PH_00;
      idx_last <= 1'b0;
      count    <= '0;
      snap     <= '0;
      flags_q  <= '0;
    end else begin
      ph_last  <= ph_new;
      idx_last <= idx_f;
      if (clr) begin
        count <= '0;
      end else if (idx_load) begin
        count <= INDEX_VAL;
      end else if (!freeze) begin
        case (step)
          STEP_UP: count <= count + WIDTH'(1);
          STEP_DN: count <= count - WIDTH'(1);
          default: count <= count;
        endcase
      end
      // A set in the same cycle as clr_flags wins.
      flags_q <= (flags_q & ~{4{clr_flags}}) | flags_set;
      if (latch) begin
        snap <= count;
      end
    end
  end

  assign ovf      = flags_q.ovf;
  assign unf      = flags_q.unf;
  assign err      = flags_q.err;
  assign idx_seen = flags_q.idx_seen;

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (rd_sel == SELW'(i)) begin
        rd_data = snap[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_qcounter_param.sv
// Scoreboard bench for qcounter_param: WIDTH=16, FILT_DEPTH=4, INDEX_VAL=100.
module tb_qcounter_param;

  localparam int unsigned W  = 16;
  localparam int unsigned FD = 4;

  typedef struct {
    logic [W-1:0] cnt;
    logic [3:0]   flg;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         filterce;
  logic [1:0]   tach;
  logic         index;
  logic         invphase;
  logic         freeze;
  logic         idx_en;
  logic         clr;
  logic         clr_flags;
  logic         latch;
  logic [0:0]   rd_sel;
  logic [7:0]   rd_data;
  logic [W-1:0] count;
  logic         ovf, unf, err, idx_seen;

  int           vectors = 0;
  int           miscompares = 0;
  exp_t         exp_q[$];
  logic [7:0]   rd_q[$];
  logic [1:0]   pos = 2'd0;
  logic [W-1:0] mcount = '0;
  logic [3:0]   mflags = '0;   // {ovf, unf, err, idx_seen}

  qcounter_param #(.WIDTH(W), .FILT_DEPTH(FD), .INDEX_VAL(16'd100)) dut (
    .clk(clk), .reset(reset), .filterce(filterce), .tach(tach), .index(index),
    .invphase(invphase), .freeze(freeze), .idx_en(idx_en), .clr(clr),
    .clr_flags(clr_flags), .latch(latch), .rd_sel(rd_sel), .rd_data(rd_data),
    .count(count), .ovf(ovf), .unf(unf), .err(err), .idx_seen(idx_seen)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [1:0] p);
    case (p)
      2'd0: enc = 2'b00;
      2'd1: enc = 2'b01;
      2'd2: enc = 2'b11;
      default: enc = 2'b10;
    endcase
  endfunction

  task automatic settle();
    repeat (FD + 6) @(negedge clk);
  endtask

  task automatic move(input int dir, input bit fast);
    pos  = pos + 2'(dir);
    tach = enc(pos);
    if (fast) repeat (FD + 1) @(negedge clk);
    else settle();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mcount = '0;
  endtask

  task automatic pulse_clr_flags();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    mflags = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; filterce = 1'b1; tach = 2'b00; index = 1'b0; invphase = 1'b0;
    freeze = 1'b0; idx_en = 1'b0; clr = 1'b0; clr_flags = 1'b0; latch = 1'b0;
    rd_sel = 1'b0;
    exp_q.push_back('{cnt: '0, flg: 4'b0000});
    rd_q.push_back(8'h00);
    repeat (3) @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (count !== e.cnt) begin
      miscompares++; $display("FAIL reset_count: got %h want %h", count, e.cnt);
    end
    vectors++;
    if ({ovf, unf, err, idx_seen} !== e.flg) begin
      miscompares++; $display("FAIL reset_flags: got %b want %b", {ovf, unf, err, idx_seen}, e.flg);
    end
    vectors++;
    if (rd_data !== rd_q[0]) begin
      miscompares++; $display("FAIL reset_rd_data: got %h want %h", rd_data, rd_q[0]);
    end
    void'(rd_q.pop_front());
    reset = 1'b0;
    settle();
  endtask

  task automatic test_latency();
    exp_t e;
    pos = pos + 2'd1;
    tach = enc(pos);
    exp_q.push_back('{cnt: mcount, flg: mflags});
    mcount = mcount + 16'd1;
    exp_q.push_back('{cnt: mcount, flg: mflags});
    repeat (FD + 3) @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (count !== e.cnt) begin
      miscompares++; $display("FAIL latency_early: got %h want %h", count, e.cnt);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (count !== e.cnt) begin
      miscompares++; $display("FAIL latency_edge: got %h want %h", count, e.cnt);
    end
    move(-1, 1'b0);
    mcount = mcount - 16'd1;
  endtask

  task automatic test_up_down();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      if (i < 20) begin
        mcount = mcount + 16'd1;
        exp_q.push_back('{cnt: mcount, flg: mflags});
        move(1, 1'b0);
      end else begin
        mcount = mcount - 16'd1;
        exp_q.push_back('{cnt: mcount, flg: mflags});
        move(-1, 1'b0);
      end
      e = exp_q.pop_front();
      vectors++;
      if (count !== e.cnt) begin
        miscompares++; $display("FAIL up_down_count[%0d]: got %h want %h", i, count, e.cnt);
      end
      vectors++;
      if ({ovf, unf, err, idx_seen} !== e.flg) begin
        miscompares++;
        $display("FAIL up_down_flags[%0d]: got %b want %b", i, {ovf, unf, err, idx_seen}, e.flg);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin mcount = 16'hFFFF; mflags[2] = 1'b1; move(-1, 1'b0); end
        1: begin mcount = 16'h0000; mflags[3] = 1'b1; move(1, 1'b0); end
        default: pulse_clr_flags();
      endcase
      exp_q.push_back('{cnt: mcount, flg: mflags});
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (count !== e.cnt) begin
        miscompares++; $display("FAIL wrap_count[%0d]: got %h want %h", i, count, e.cnt);
      end
      vectors++;
      if ({ovf, unf, err, idx_seen} !== e.flg) begin
        miscompares++;
        $display("FAIL wrap_flags[%0d]: got %b want %b", i, {ovf, unf, err, idx_seen}, e.flg);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    tach = enc(pos) ^ 2'b01;
    repeat (FD - 2) @(negedge clk);
    tach = enc(pos);
    exp_q.push_back('{cnt: mcount, flg: mflags});
    settle();
    e = exp_q.pop_front();
    vectors++;
    if ({count, ovf, unf, err, idx_seen} !== {e.cnt, e.flg}) begin
      miscompares++;
      $display("FAIL glitch: got %h/%b want %h/%b", count, {ovf, unf, err, idx_seen}, e.cnt, e.flg);
    end
    pos = pos + 2'd2;
    tach = enc(pos);
    mflags[1] = 1'b1;
    exp_q.push_back('{cnt: mcount, flg: mflags});
    settle();
    e = exp_q.pop_front();
    vectors++;
    if ({count, ovf, unf, err, idx_seen} !== {e.cnt, e.flg}) begin
      miscompares++;
      $display("FAIL illegal_jump: got %h/%b want %h/%b", count, {ovf, unf, err, idx_seen}, e.cnt, e.flg);
    end
    pulse_clr_flags();
  endtask

  task automatic test_index();
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      pulse_clr_flags();
      pulse_clr();
      for (int i = 0; i < 37; i++) move(1, 1'b1);
      mcount = 16'd37;
      exp_q.push_back('{cnt: mcount, flg: mflags});
      settle();
      e = exp_q.pop_front();
      vectors++;
      if (count !== e.cnt) begin
        miscompares++; $display("FAIL index_pre[%0d]: got %h want %h", pass, count, e.cnt);
      end
      idx_en = (pass == 0);
      index = 1'b1;
      if (pass == 0) begin
        mcount = 16'd100; mflags[0] = 1'b1;
      end else begin
        mcount = 16'd38;
      end
      exp_q.push_back('{cnt: mcount, flg: mflags});
      move(1, 1'b0);
      e = exp_q.pop_front();
      vectors++;
      if ({count, ovf, unf, err, idx_seen} !== {e.cnt, e.flg}) begin
        miscompares++;
        $display("FAIL index_load[%0d]: got %h/%b want %h/%b", pass, count,
                 {ovf, unf, err, idx_seen}, e.cnt, e.flg);
      end
      index = 1'b0;
      settle();
    end
    idx_en = 1'b0;
  endtask

  task automatic test_snapshot();
    exp_t e;
    pulse_clr();
    for (int i = 0; i < 16'h12FF; i++) move(1, 1'b1);
    mcount = 16'h12FF;
    settle();
    pos = pos + 2'd1;
    tach = enc(pos);
    repeat (FD + 3) @(negedge clk);
    latch = 1'b1;
    @(negedge clk);
    latch = 1'b0;
    mcount = 16'h1300;
    exp_q.push_back('{cnt: mcount, flg: mflags});
    rd_q.push_back(8'hFF);
    rd_q.push_back(8'h12);
    e = exp_q.pop_front();
    vectors++;
    if (count !== e.cnt) begin
      miscompares++; $display("FAIL snap_live_count: got %h want %h", count, e.cnt);
    end
    for (int b = 0; b < 2; b++) begin
      rd_sel = 1'(b);
      #1;
      vectors++;
      if (rd_data !== rd_q[0]) begin
        miscompares++; $display("FAIL snap_byte[%0d]: got %h want %h", b, rd_data, rd_q[0]);
      end
      void'(rd_q.pop_front());
    end
    latch = 1'b1;
    mcount = 16'h1301;
    rd_q.push_back(8'h01);
    move(1, 1'b0);
    rd_sel = 1'b0;
    #1;
    vectors++;
    if (rd_data !== rd_q[0]) begin
      miscompares++; $display("FAIL snap_held_latch: got %h want %h", rd_data, rd_q[0]);
    end
    void'(rd_q.pop_front());
    latch = 1'b0;
  endtask

  task automatic test_freeze();
    exp_t e;
    while (pos != 2'd0) begin
      move(1, 1'b1);
      mcount = mcount + 16'd1;
    end
    settle();
    for (int ph = 0; ph < 3; ph++) begin
      if (ph == 0) freeze = 1'b1;
      if (ph == 2) begin invphase = 1'b1; settle(); end
      if (ph != 1) for (int i = 0; i < 8; i++) move(1, 1'b1);
      if (ph == 1) freeze = 1'b0;
      if (ph == 2) mcount = mcount - 16'd8;
      exp_q.push_back('{cnt: mcount, flg: mflags});
      settle();
      e = exp_q.pop_front();
      vectors++;
      if ({count, ovf, unf, err, idx_seen} !== {e.cnt, e.flg}) begin
        miscompares++;
        $display("FAIL freeze_phase[%0d]: got %h/%b want %h/%b", ph, count,
                 {ovf, unf, err, idx_seen}, e.cnt, e.flg);
      end
    end
    invphase = 1'b0;
    settle();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    while (pos != 2'd2) begin
      move(1, 1'b1);
      mcount = mcount + 16'd1;
    end
    settle();
    reset = 1'b1;
    mcount = '0;
    mflags = '0;
    exp_q.push_back('{cnt: mcount, flg: mflags});
    #1;
    e = exp_q.pop_front();
    vectors++;
    if ({count, ovf, unf, err, idx_seen} !== {e.cnt, e.flg}) begin
      miscompares++;
      $display("FAIL reset_async: got %h/%b want %h/%b", count, {ovf, unf, err, idx_seen}, e.cnt, e.flg);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mflags[1] = 1'b1;
    exp_q.push_back('{cnt: mcount, flg: mflags});
    settle();
    e = exp_q.pop_front();
    vectors++;
    if ({count, ovf, unf, err, idx_seen} !== {e.cnt, e.flg}) begin
      miscompares++;
      $display("FAIL reset_release: got %h/%b want %h/%b", count, {ovf, unf, err, idx_seen}, e.cnt, e.flg);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_up_down();
    test_wrap();
    test_glitch();
    test_index();
    test_snapshot();
    test_freeze();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
